mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one downstream memory port between instruction fetch (I, read-only) and
//  load/store (D, read/write) requesters, for the unified-memory processor variant.
//  Serialises accesses (one outstanding), routes responses back to the owner, and
//  gives D priority with a starvation guard for I.
// PARAMETERS
//  ADDR_WIDTH    32  address width of all ports
//  DATA_WIDTH    32  data width; byte enables are DATA_WIDTH/8 bits
//  STARVE_LIMIT  4   consecutive D wins while i_req is pending before I is forced
// PORTS
//  clk       in   1    single clock, rising edge
//  rst       in   1    synchronous, active-high reset
//  i_req     in   1    fetch request; held with i_addr stable until i_gnt
//  i_addr    in   AW   fetch address
//  i_gnt     out  1    fetch request accepted this cycle
//  i_rvalid  out  1    fetch response valid (1 cycle)
//  i_rdata   out  DW   fetch response data
//  d_req     in   1    data request; held with d_* stable until d_gnt
//  d_we      in   1    1 = store, 0 = load
//  d_be      in   DW/8 byte enables (stores)
//  d_addr    in   AW   data address
//  d_wdata   in   DW   store data
//  d_gnt     out  1    data request accepted this cycle
//  d_rvalid  out  1    data response/store ack valid (1 cycle)
//  d_rdata   out  DW   load data
//  m_req     out  1    memory request
//  m_we      out  1    memory write
//  m_be      out  DW/8 memory byte enables
//  m_addr    out  AW   memory address
//  m_wdata   out  DW   memory write data
//  m_gnt     in   1    memory accepted request (same cycle)
//  m_rvalid  in   1    memory response, >=1 cycle after m_gnt
//  m_rdata   in   DW   memory read data
//  busy      out  1    state != IDLE
//  err_unexp out  1    sticky: m_rvalid seen with no outstanding access
// BEHAVIOUR
//  - Reset: state=IDLE, starve_cnt=0, err_unexp=0; all gnt/rvalid/m_req/m_we = 0.
//  - FSM states: IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D.
//  - Winner (IDLE only): D if d_req and not (i_req and starve_cnt==STARVE_LIMIT),
//    else I if i_req. Computed combinationally.
//  - IDLE: m_* driven from winner; m_req=1 if any req. If m_gnt is high, x_gnt=1 in
//    the same cycle and next state=WAIT_x; otherwise next state=REQ_x (owner locked).
//  - REQ_x: m_* from owner x only; a new request on the other port is ignored.
//    On m_gnt: x_gnt=1, next state=WAIT_x.
//  - WAIT_x: m_req=0. On m_rvalid: x_rvalid=1, x_rdata=m_rdata, next state=IDLE.
//    Store ack uses d_rvalid with don't-care d_rdata.
//  - Minimum 2 cycles per access (gnt cycle, then rvalid cycle); no pipelining.
//  - m_we/m_be/m_wdata are 0 when owner is I or no request is active.
//  - Inactive rvalid is 0. Inactive rdata is 0.
//  - starve_cnt updates on each grant:
//    - D granted while i_req high: +1, saturating at STARVE_LIMIT.
//    - I granted: cleared to 0.
//    - Cycle with i_req low: cleared to 0.
//  - m_rvalid in IDLE/REQ_x: ignored for routing and sets err_unexp.
//  - Reset mid-access: returns to IDLE immediately and the outstanding response is
//    dropped. Downstream memory must be reset together with this block.
//  - Simultaneous i_req and d_req in IDLE: D wins unless the starvation rule applies.
// TESTING
//  1. Reset -> all outputs 0, busy=0; m_rvalid pulse after reset -> err_unexp=1.
//  2. i_req, addr 0x10, m_gnt same cycle, m_rvalid next cycle with 0xDEADBEEF
//     -> i_gnt at cycle 0, i_rvalid=1 with i_rdata=0xDEADBEEF at cycle 1,
//     d_rvalid=0 throughout.
//  3. i_req and d_req together (store, be=4'b0011, 0x20) -> D granted first with
//     m_we=1, m_be=4'b0011; I granted in the next IDLE.
//  4. m_gnt delayed 3 cycles on I; d_req asserted in REQ_I -> m_addr stays I's
//     address; D served only after I's rvalid.
//  5. i_req held with continuous d_req, STARVE_LIMIT=4 -> 4 D grants, then I granted;
//     starve_cnt returns to 0.
//  6. rst asserted in WAIT_D, then m_rvalid arrives -> no d_rvalid, state IDLE,
//     err_unexp=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one downstream memory port between an instruction-fetch requester (I,
// read-only) and a load/store requester (D, read/write). Only one access is in
// flight at a time. Each response goes back to the requester that owns the
// access. D has priority. A starvation counter forces an I grant after
// STARVE_LIMIT consecutive D grants while I is waiting.
//
// Ports
//   clk, rst           clock and synchronous active-high reset
//   i_req/i_addr       fetch request (held stable until i_gnt)
//   i_gnt/i_rvalid     fetch accept and fetch response strobes
//   i_rdata            fetch response data (0 when i_rvalid is low)
//   d_req/d_we/d_be    load/store request (held stable until d_gnt)
//   d_addr/d_wdata
//   d_gnt/d_rvalid     load/store accept and response/ack strobes
//   d_rdata            load data (0 when d_rvalid is low)
//   m_req/m_we/m_be    downstream memory request
//   m_addr/m_wdata
//   m_gnt              memory accepts the request in the same cycle
//   m_rvalid/m_rdata   memory response, at least one cycle after m_gnt
//   busy               an access is owned (state != IDLE)
//   err_unexp          sticky: m_rvalid seen with no outstanding access
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_gnt,
    output logic                    i_rvalid,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    m_req,
    output logic                    m_we,
    output logic [DATA_WIDTH/8-1:0] m_be,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    input  logic                    m_gnt,
    input  logic                    m_rvalid,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    output logic                    busy,
    output logic                    err_unexp
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        REQ_I,
        REQ_D,
        WAIT_I,
        WAIT_D
    } state_e;

    state_e        state_q;
    logic [CW-1:0] starve_q;
    logic          err_q;

    logic win_d, win_i;
    logic sel_i, sel_d;

    // Arbitration only matters in IDLE; once a requester owns the port the
    // other side is ignored until the response returns.
    always_comb begin
        win_d = d_req && !(i_req && (starve_q == LIMIT));
        win_i = !win_d && i_req;

        sel_i = 1'b0;
        sel_d = 1'b0;
        case (state_q)
            IDLE:    begin sel_i = win_i; sel_d = win_d; end
            REQ_I:   sel_i = 1'b1;
            REQ_D:   sel_d = 1'b1;
            default: ;
        endcase
        // Nothing is presented downstream while reset is held.
        if (rst) begin
            sel_i = 1'b0;
            sel_d = 1'b0;
        end
    end

    always_comb begin
        m_req   = sel_i || sel_d;
        m_we    = sel_d && d_we;
        m_be    = sel_d ? d_be : '0;
        m_wdata = sel_d ? d_wdata : '0;
        m_addr  = sel_d ? d_addr : (sel_i ? i_addr : '0);

        i_gnt   = sel_i && m_gnt;
        d_gnt   = sel_d && m_gnt;

        i_rvalid = !rst && (state_q == WAIT_I) && m_rvalid;
        d_rvalid = !rst && (state_q == WAIT_D) && m_rvalid;
        i_rdata  = i_rvalid ? m_rdata : '0;
        d_rdata  = d_rvalid ? m_rdata : '0;

        busy      = (state_q != IDLE);
        err_unexp = err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            // A response is only legal while waiting on an accepted access.
            if (m_rvalid && (state_q != WAIT_I) && (state_q != WAIT_D))
                err_q <= 1'b1;

            // Counts D grants that happen while a fetch is waiting.
            if (!i_req || i_gnt)
                starve_q <= '0;
            else if (d_gnt && (starve_q != LIMIT))
                starve_q <= starve_q + 1'b1;

            case (state_q)
                IDLE: begin
                    if (win_d)
                        state_q <= m_gnt ? WAIT_D : REQ_D;
                    else if (win_i)
                        state_q <= m_gnt ? WAIT_I : REQ_I;
                end
                REQ_I:  if (m_gnt)    state_q <= WAIT_I;
                REQ_D:  if (m_gnt)    state_q <= WAIT_D;
                WAIT_I: if (m_rvalid) state_q <= IDLE;
                WAIT_D: if (m_rvalid) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Byte-enable width is tied to the data width.
    if (BW * 8 != DATA_WIDTH) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of 8");
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt, i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          m_req, m_we;
    logic [3:0]    m_be;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_gnt, m_rvalid;
    logic [DW-1:0] m_rdata;
    logic          busy, err_unexp;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .busy(busy), .err_unexp(err_unexp)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the port (0 none, 1 I, 2 D), whether memory
    // has accepted that owner's access, the starvation count and sticky error.
    int mo_owner  = 0;
    bit mo_gr     = 0;
    int mo_starve = 0;
    bit mo_err    = 0;

    // Observations from the last checked cycle, for directed checks.
    logic          ob_ig, ob_dg, ob_irv, ob_drv, ob_mg, ob_we, ob_busy, ob_err;
    logic [3:0]    ob_be;
    logic [AW-1:0] ob_addr;
    logic [DW-1:0] ob_ird, ob_drd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare every output against the model at the falling
    // edge, then advance the model with the inputs that were applied.
    task automatic cycle();
        int   pick;
        logic act, e_ig, e_dg, e_irv, e_drv;
        @(negedge clk);
        pick = mo_owner;
        if (pick == 0) begin
            if (d_req && !(i_req && mo_starve == LIMIT)) pick = 2;
            else if (i_req) pick = 1;
        end
        act   = !rst && !mo_gr && (pick != 0);
        e_ig  = act && m_gnt && pick == 1;
        e_dg  = act && m_gnt && pick == 2;
        e_irv = !rst && mo_gr && mo_owner == 1 && m_rvalid;
        e_drv = !rst && mo_gr && mo_owner == 2 && m_rvalid;

        chk("m_req",    m_req,    act);
        chk("m_addr",   m_addr,   act ? (pick == 1 ? i_addr : d_addr) : '0);
        chk("m_we",     m_we,     act && pick == 2 && d_we);
        chk("m_be",     m_be,     (act && pick == 2) ? d_be : 4'h0);
        chk("m_wdata",  m_wdata,  (act && pick == 2) ? d_wdata : '0);
        chk("i_gnt",    i_gnt,    e_ig);
        chk("d_gnt",    d_gnt,    e_dg);
        chk("i_rvalid", i_rvalid, e_irv);
        chk("d_rvalid", d_rvalid, e_drv);
        chk("i_rdata",  i_rdata,  e_irv ? m_rdata : '0);
        chk("d_rdata",  d_rdata,  e_drv ? m_rdata : '0);
        chk("busy",     busy,     mo_owner != 0);
        chk("err",      err_unexp, mo_err);

        ob_ig = i_gnt;  ob_dg = d_gnt;  ob_irv = i_rvalid; ob_drv = d_rvalid;
        ob_mg = m_req && m_gnt; ob_we = m_we; ob_be = m_be; ob_addr = m_addr;
        ob_ird = i_rdata; ob_drd = d_rdata; ob_busy = busy; ob_err = err_unexp;

        if (rst) begin
            mo_owner = 0; mo_gr = 0; mo_starve = 0; mo_err = 0;
        end else begin
            if (m_rvalid && !mo_gr) mo_err = 1;
            if (!i_req || e_ig) mo_starve = 0;
            else if (e_dg && mo_starve < LIMIT) mo_starve++;
            if (mo_gr && m_rvalid) begin
                mo_owner = 0; mo_gr = 0;
            end else if (act) begin
                mo_owner = pick;
                if (m_gnt) mo_gr = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
        m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    endtask

    initial begin
        int seq[6];
        int exp_seq[6];
        bit mpend;
        int mdly;
        exp_seq = '{2, 2, 2, 2, 1, 2};

        rst = 1; idle_inputs();
        @(posedge clk); #1;

        // 1: reset state, then a stray response sets the sticky error
        cycle();
        rst = 0;
        cycle();
        chk("t1_busy0", ob_busy, 1'b0);
        chk("t1_err0",  ob_err,  1'b0);
        m_rvalid = 1; m_rdata = 32'h1234_5678;
        cycle();
        chk("t1_stray_rv", ob_irv | ob_drv, 1'b0);
        m_rvalid = 0;
        cycle();
        chk("t1_err1", ob_err, 1'b1);
        rst = 1; cycle(); rst = 0;

        // 2: single fetch, granted immediately, response next cycle
        i_req = 1; i_addr = 32'h10; m_gnt = 1;
        cycle();
        chk("t2_igat0", ob_ig, 1'b1);
        chk("t2_addr",  ob_addr, 32'h10);
        i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'hDEAD_BEEF;
        cycle();
        chk("t2_irv",   ob_irv, 1'b1);
        chk("t2_irdat", ob_ird, 32'hDEAD_BEEF);
        chk("t2_drv",   ob_drv, 1'b0);
        m_rvalid = 0;

        // 3: simultaneous requests, D store wins, I next
        i_req = 1; i_addr = 32'h14;
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h20; d_wdata = 32'hCAFE_F00D;
        m_gnt = 1;
        cycle();
        chk("t3_dgnt", ob_dg, 1'b1);
        chk("t3_ignt", ob_ig, 1'b0);
        chk("t3_we",   ob_we, 1'b1);
        chk("t3_be",   ob_be, 4'b0011);
        d_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h0;
        cycle();
        chk("t3_dack", ob_drv, 1'b1);
        m_rvalid = 0; m_gnt = 1;
        cycle();
        chk("t3_ignt2", ob_ig, 1'b1);
        chk("t3_iaddr", ob_addr, 32'h14);
        i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h0BAD_F00D;
        cycle();
        chk("t3_irv", ob_irv, 1'b1);
        m_rvalid = 0; d_we = 0; d_be = 0;

        // 4: I owns the port while m_gnt is delayed; late D request waits
        i_req = 1; i_addr = 32'h40;
        cycle();
        chk("t4_a0", ob_addr, 32'h40);
        d_req = 1; d_addr = 32'h80;
        cycle();
        chk("t4_a1", ob_addr, 32'h40);
        chk("t4_dg1", ob_dg, 1'b0);
        cycle();
        chk("t4_a2", ob_addr, 32'h40);
        m_gnt = 1;
        cycle();
        chk("t4_ig", ob_ig, 1'b1);
        chk("t4_dg3", ob_dg, 1'b0);
        i_req = 0; m_gnt = 0;
        cycle();
        chk("t4_dgw", ob_dg, 1'b0);
        m_rvalid = 1; m_gnt = 1; m_rdata = 32'h4444_0000;
        cycle();
        chk("t4_irv", ob_irv, 1'b1);
        chk("t4_dgrv", ob_dg, 1'b0);
        m_rvalid = 0;
        cycle();
        chk("t4_dg", ob_dg, 1'b1);
        chk("t4_da", ob_addr, 32'h80);
        d_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h8888_0000;
        cycle();
        chk("t4_drv", ob_drv, 1'b1);
        chk("t4_drd", ob_drd, 32'h8888_0000);
        m_rvalid = 0;
        cycle();

        // 5: starvation guard: four D grants, then I, then D again
        i_req = 1; i_addr = 32'h100; d_req = 1; d_addr = 32'h200;
        for (int k = 0; k < 6; k++) begin
            m_gnt = 1; m_rvalid = 0;
            cycle();
            seq[k] = ob_ig ? 1 : (ob_dg ? 2 : 0);
            m_gnt = 0; m_rvalid = 1; m_rdata = $urandom;
            cycle();
        end
        for (int k = 0; k < 6; k++) chk($sformatf("t5_win%0d", k), seq[k], exp_seq[k]);
        idle_inputs();
        cycle();

        // 6: reset during WAIT_D drops the response and flags it as unexpected
        d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h300; d_wdata = 32'h5A5A_5A5A; m_gnt = 1;
        cycle();
        chk("t6_dg", ob_dg, 1'b1);
        chk("t6_err0", ob_err, 1'b0);
        d_req = 0; m_gnt = 0; rst = 1;
        cycle();
        chk("t6_drv_rst", ob_drv, 1'b0);
        rst = 0; m_rvalid = 1;
        cycle();
        chk("t6_drv", ob_drv, 1'b0);
        chk("t6_busy", ob_busy, 1'b0);
        m_rvalid = 0;
        cycle();
        chk("t6_err", ob_err, 1'b1);

        // Randomised traffic with a memory that answers after 1-3 cycles
        rst = 1; idle_inputs(); cycle(); rst = 0;
        mpend = 0; mdly = 0;
        for (int n = 0; n < 2000; n++) begin
            if (ob_ig) i_req = 0;
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1; i_addr = $urandom;
            end
            if (ob_dg) d_req = 0;
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom_range(0, 15));
                d_addr = $urandom; d_wdata = $urandom;
            end
            m_gnt = ($urandom_range(0, 2) != 0);
            m_rvalid = 0;
            if (ob_mg) begin
                mpend = 1; mdly = $urandom_range(0, 2);
            end else if (mpend) begin
                if (mdly == 0) begin
                    m_rvalid = 1; m_rdata = $urandom; mpend = 0;
                end else mdly--;
            end else if ($urandom_range(0, 199) == 0) begin
                m_rvalid = 1; m_rdata = $urandom;
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
